pkt_dispatch: RTL and testbench
===============================

# pkt_dispatch

Ingress/egress stage wrapped around the packet processor. Receives a packet as a 32-bit word stream and writes it into the shared packet memory at a fixed buffer base. Starts the processor with the buffer address and waits for completion. Then reads the (possibly modified) packet back out of memory onto an egress word stream. While the processor runs, the block hands the memory port over to it.

## Interface
Parameters:
- BUF_BASE, 32'h0000_0100, byte address of packet buffer (word aligned); also driven on proc_pkt_addr_o
- MAX_WORDS, 64, buffer capacity in 32-bit words (power of two not required, ≥1)

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in_valid_i / in_ready_o  input/output  1  ingress handshake; transfer when both high at posedge
- in_data_i  input  32  ingress word, byte 0 in [7:0]
- in_last_i  input  1  final word of packet
- in_bytes_i  input  3  valid bytes in final word (1..4; ignored unless in_last_i)
- out_valid_o / out_ready_i  output/input  1  egress handshake
- out_data_o  output  32  egress word
- out_last_o  output  1  final egress word
- out_bytes_o  output  3  valid bytes in final word (4 on non-final words)
- proc_start_o  output  1  processor start level
- proc_pkt_addr_o  output  `ADDR_BUS  equals BUF_BASE
- proc_ready_i  input  1  processor done
- mem_sel_o  output  1  1 = processor owns memory port, 0 = this block
- mem_ce_o, mem_we_o  output  1  memory enable / write
- mem_addr_o  output  `ADDR_BUS  byte address
- mem_width_o  output  4  access width in bytes
- mem_data_o  output  `DATA_BUS  write data
- mem_data_i  input  `DATA_BUS  read data, combinational from mem_addr_o (same-cycle)

## Operation
States: IDLE, RECV, DROP, PROC, SEND.
- IDLE: in_ready_o=1. On an accepted word, write it to BUF_BASE and set idx=1. If in_last_i is high, latch last_bytes and go to PROC. Otherwise go to RECV.
- RECV: in_ready_o=1. Each accepted word is written to BUF_BASE+4*idx, and idx increments.
  - Write width is 4, or in_bytes_i on the last word.
  - On last: latch nwords=idx+1 and last_bytes, then go to PROC.
  - If a word arrives with idx==MAX_WORDS, it is not written. The block goes to DROP, or to IDLE directly if that word carried in_last_i.
- DROP: in_ready_o=1. Words are discarded with no memory access. On the last word, go to IDLE.
- PROC: mem_sel_o=1, proc_start_o=1, mem_ce_o=0. When proc_ready_i is sampled high: proc_start_o=0, mem_sel_o=0, idx=0, go to SEND.
- SEND: out_valid_o=1, mem_ce_o=1, mem_we_o=0, mem_addr_o=BUF_BASE+4*idx. out_data_o is mem_data_i, passed through combinationally.
  - Width is 4, or last_bytes on idx==nwords-1, where out_last_o=1.
  - On out_ready_i: idx increments. After the last word, go to IDLE.
- in_bytes_i of 0 or >4 on a last word is treated as 4.
- idx is $clog2(MAX_WORDS+1) bits wide and never wraps.

## Timing
- Reset values:
  - state IDLE; idx=0.
  - in_ready_o=0 during rst, 1 from the first non-reset cycle.
  - out_valid_o=0, out_last_o=0, out_bytes_o=0, out_data_o passes mem_data_i but is don't-care while out_valid_o=0.
  - proc_start_o=0, mem_sel_o=0.
  - mem_ce_o=0, mem_we_o=0, mem_addr_o=0, mem_width_o=0, mem_data_o=0.
- Ingress writes are combinational from the handshake: mem_ce_o=mem_we_o=in_valid_i&in_ready_o in the same cycle, and the write commits at that posedge. Sustained 1 word/cycle.
- The last ingress word at edge N puts the block in PROC at N+1, with proc_start_o high from N+1.
- proc_ready_i high at edge M makes proc_start_o low at M+1, and the first egress word is valid at M+1.
- Egress holds out_data_o/out_last_o stable while out_valid_o & !out_ready_i. Throughput is 1 word/cycle.
- in_ready_o=0 in PROC and SEND, so ingress back-pressures.
- rst mid-packet aborts any state to IDLE in 1 cycle. Partial buffer contents are abandoned and proc_start_o drops.
- Total packet latency, last ingress word to first egress word: processor latency + 1 cycle.

## Configuration
- DISPATCH_STATS_EN defined: adds outputs pkt_cnt_o[15:0] and drop_cnt_o[15:0], both saturating at 16'hFFFF and reset to 0.
  - pkt_cnt_o increments when the final egress word is accepted.
  - drop_cnt_o increments on entry to DROP, or on the direct overflow-with-last case.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- 3-word packet 0x11223344, 0x55667788, 0xAABBCCDD, with last in_bytes=2:
  - writes go to 0x100/0x104/0x108 with widths 4/4/2.
  - proc_start_o rises 1 cycle after the last word and stays high until proc_ready_i.
  - egress shows 3 words, out_last_o on the third, out_bytes_o=2.
- Single-word packet with in_last_i on the first beat: goes IDLE→PROC directly and emits one egress word with out_last_o=1.
- MAX_WORDS=4, 6-word packet:
  - 4 writes only, then DROP; words 5–6 are accepted with no mem_ce_o.
  - Returns to IDLE, no proc_start_o; drop_cnt_o=1 with DISPATCH_STATS_EN.
- Egress back-pressure: out_ready_i toggles 1,0,0,1. Data, address and out_last_o are held stable during stall cycles, and no word is skipped or duplicated.
- Processor slow (proc_ready_i after 20 cycles): mem_sel_o=1 and in_ready_o=0 for the whole PROC window, and ingress in_valid_i is stalled.
- rst asserted in RECV after 2 words: next cycle in IDLE with in_ready_o=1, proc_start_o=0. A following 1-word packet is processed normally.

Source files
------------

// File: rtl/pkt_dispatch.sv
// Packet dispatch stage: ingress stream -> packet buffer, processor hand-off, buffer -> egress stream.
// Optional build macro DISPATCH_STATS_EN adds saturating packet/drop counters (pkt_cnt_o, drop_cnt_o).

`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif

module pkt_dispatch #(
    parameter logic [31:0] BUF_BASE  = 32'h0000_0100,
    parameter int          MAX_WORDS = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_data_i,
    input  logic             in_last_i,
    input  logic [2:0]       in_bytes_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_data_o,
    output logic             out_last_o,
    output logic [2:0]       out_bytes_o,
    output logic             proc_start_o,
    output logic [`ADDR_BUS] proc_pkt_addr_o,
    input  logic             proc_ready_i,
    output logic             mem_sel_o,
    output logic             mem_ce_o,
    output logic             mem_we_o,
    output logic [`ADDR_BUS] mem_addr_o,
    output logic [3:0]       mem_width_o,
    output logic [`DATA_BUS] mem_data_o,
    input  logic [`DATA_BUS] mem_data_i
`ifdef DISPATCH_STATS_EN
    ,
    output logic [15:0]      pkt_cnt_o,
    output logic [15:0]      drop_cnt_o
`endif
);

    localparam int            IW       = $clog2(MAX_WORDS + 1);
    localparam logic [IW-1:0] IDX_FULL = IW'(MAX_WORDS);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RECV = 3'd1;
    localparam logic [2:0] S_DROP = 3'd2;
    localparam logic [2:0] S_PROC = 3'd3;
    localparam logic [2:0] S_SEND = 3'd4;

    logic [2:0]      state;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   last_idx;     // index of the final word, i.e. nwords-1
    logic [2:0]      last_bytes;
    logic [2:0]      in_bytes_norm;
    logic [2:0]      send_bytes;
    logic [`ADDR_BUS] word_addr;
    logic            in_fire;
    logic            out_fire;
    logic            overflow;
    logic            wr_en;
    logic            idx_at_last;

    assign in_bytes_norm   = (in_bytes_i == 3'd0 || in_bytes_i > 3'd4) ? 3'd4 : in_bytes_i;
    assign word_addr       = BUF_BASE + (32'(idx) << 2);
    assign proc_pkt_addr_o = BUF_BASE;
    assign out_data_o      = mem_data_i;

    // Ready is held low while rst is asserted so nothing is accepted in the reset cycle.
    assign in_ready_o  = !rst && (state == S_IDLE || state == S_RECV || state == S_DROP);
    assign in_fire     = in_valid_i && in_ready_o;
    assign overflow    = (state == S_RECV) && (idx == IDX_FULL);
    assign wr_en       = in_fire && (state == S_IDLE || (state == S_RECV && !overflow));
    assign idx_at_last = (idx == last_idx);
    assign send_bytes  = idx_at_last ? last_bytes : 3'd4;
    assign out_fire    = out_valid_o && out_ready_i;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        out_valid_o  = 1'b0;
        out_last_o   = 1'b0;
        out_bytes_o  = 3'd0;
        proc_start_o = 1'b0;
        mem_sel_o    = 1'b0;
        mem_ce_o     = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_width_o  = 4'd0;
        mem_data_o   = '0;
        if (wr_en) begin
            mem_ce_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = word_addr;
            mem_width_o = in_last_i ? {1'b0, in_bytes_norm} : 4'd4;
            mem_data_o  = in_data_i;
        end
        if (!rst && state == S_PROC) begin
            proc_start_o = 1'b1;
            mem_sel_o    = 1'b1;
        end
        if (!rst && state == S_SEND) begin
            out_valid_o = 1'b1;
            out_last_o  = idx_at_last;
            out_bytes_o = send_bytes;
            mem_ce_o    = 1'b1;
            mem_addr_o  = word_addr;
            mem_width_o = {1'b0, send_bytes};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            last_idx   <= '0;
            last_bytes <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_fire) begin
                        idx <= IW'(1);
                        if (in_last_i) begin
                            last_idx   <= '0;
                            last_bytes <= in_bytes_norm;
                            state      <= S_PROC;
                        end else begin
                            state <= S_RECV;
                        end
                    end
                end
                S_RECV: begin
                    if (in_fire) begin
                        if (overflow) begin
                            idx   <= '0;
                            state <= in_last_i ? S_IDLE : S_DROP;
                        end else begin
                            idx <= idx + IW'(1);
                            if (in_last_i) begin
                                last_idx   <= idx;
                                last_bytes <= in_bytes_norm;
                                state      <= S_PROC;
                            end
                        end
                    end
                end
                S_DROP: begin
                    if (in_fire && in_last_i) begin
                        state <= S_IDLE;
                    end
                end
                S_PROC: begin
                    if (proc_ready_i) begin
                        idx   <= '0;
                        state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (out_fire) begin
                        if (idx_at_last) begin
                            idx   <= '0;
                            state <= S_IDLE;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DISPATCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_o  <= 16'd0;
            drop_cnt_o <= 16'd0;
        end else begin
            if (out_fire && idx_at_last && pkt_cnt_o != 16'hFFFF) begin
                pkt_cnt_o <= pkt_cnt_o + 16'd1;
            end
            // One event per dropped packet: the first word that finds the buffer full.
            if (in_fire && overflow && drop_cnt_o != 16'hFFFF) begin
                drop_cnt_o <= drop_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pkt_dispatch.sv
// Self-checking bench for pkt_dispatch: memory and processor models, randomized packets vs a buffer-level reference.
// Build with DISPATCH_STATS_EN defined to also check the packet/drop counters.

`timescale 1ns/1ps

`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif

module tb_pkt_dispatch;

    localparam logic [31:0] BASE   = 32'h0000_0100;
    localparam int          MAXW   = 4;
    localparam int          BASE_W = 64;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  width;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [2:0]  bytes;
        logic [31:0] addr;
    } eg_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      in_data_i;
    logic             in_last_i;
    logic [2:0]       in_bytes_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [31:0]      out_data_o;
    logic             out_last_o;
    logic [2:0]       out_bytes_o;
    logic             proc_start_o;
    logic [`ADDR_BUS] proc_pkt_addr_o;
    logic             proc_ready_i;
    logic             mem_sel_o;
    logic             mem_ce_o;
    logic             mem_we_o;
    logic [`ADDR_BUS] mem_addr_o;
    logic [3:0]       mem_width_o;
    logic [`DATA_BUS] mem_data_o;
    logic [`DATA_BUS] mem_data_i;
`ifdef DISPATCH_STATS_EN
    logic [15:0]      pkt_cnt_o;
    logic [15:0]      drop_cnt_o;
`endif

    logic [31:0] mem [0:255];
    logic [31:0] fill_words [0:MAXW-1];
    logic        fill_req;
    logic        xor_req;
    logic [31:0] xor_key;
    wr_t         wr_q [$];
    eg_t         eg_q [$];
    logic [31:0] preset [0:2];

    int checks   = 0;
    int failures = 0;
    int pkt_exp  = 0;
    int drop_exp = 0;

    always #5 clk = ~clk;

    pkt_dispatch #(.BUF_BASE(BASE), .MAX_WORDS(MAXW)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .in_data_i       (in_data_i),
        .in_last_i       (in_last_i),
        .in_bytes_i      (in_bytes_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_data_o      (out_data_o),
        .out_last_o      (out_last_o),
        .out_bytes_o     (out_bytes_o),
        .proc_start_o    (proc_start_o),
        .proc_pkt_addr_o (proc_pkt_addr_o),
        .proc_ready_i    (proc_ready_i),
        .mem_sel_o       (mem_sel_o),
        .mem_ce_o        (mem_ce_o),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_width_o     (mem_width_o),
        .mem_data_o      (mem_data_o),
        .mem_data_i      (mem_data_i)
`ifdef DISPATCH_STATS_EN
        ,
        .pkt_cnt_o       (pkt_cnt_o),
        .drop_cnt_o      (drop_cnt_o)
`endif
    );

    // Shared packet memory with same-cycle reads; the processor model edits the buffer through xor_req.
    assign mem_data_i = mem[mem_addr_o[9:2]];

    always @(posedge clk) begin
        if (fill_req) begin
            for (int k = 0; k < MAXW; k++) mem[BASE_W + k] <= fill_words[k];
        end else if (xor_req) begin
            for (int k = 0; k < MAXW; k++) mem[BASE_W + k] <= mem[BASE_W + k] ^ xor_key;
        end else if (mem_ce_o && mem_we_o) begin
            for (int b = 0; b < 4; b++) begin
                if (b < int'(mem_width_o)) mem[mem_addr_o[9:2]][8*b +: 8] <= mem_data_o[8*b +: 8];
            end
            wr_q.push_back('{addr: mem_addr_o, width: mem_width_o, data: mem_data_o});
        end
        if (out_valid_o && out_ready_i) begin
            eg_q.push_back('{data: out_data_o, last: out_last_o, bytes: out_bytes_o, addr: mem_addr_o});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called just after a negedge; returns at the negedge following the accepting posedge.
    task automatic push_word(input logic [31:0] d, input logic l, input logic [2:0] b, output int waits);
        waits      = 0;
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_last_i  = l;
        in_bytes_i = b;
        #1;
        while (!in_ready_o && waits < 200) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (!in_ready_o) begin
            checks++;
            failures++;
            $display("FAIL ingress_timeout: in_ready_o=%b after %0d cycles, want 1", in_ready_o, waits);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid_i = 1'b0;
    endtask

    task automatic run_packet(input string tag, input int n, input logic [2:0] lastb_raw,
                              input int proc_lat, input int ready_mode, input bit use_preset);
        logic [31:0] words [$];
        logic [31:0] expw [$];
        logic [31:0] v, key, hold_data, hold_addr;
        logic [2:0]  lb;
        logic        hold_last;
        int          nwr, wr0, eg0, waits, wsum, guard, cyc, ncmp;
        bit          dropped, bad, stalled;
        wr_t         w;
        eg_t         e;

        lb      = (lastb_raw == 3'd0 || lastb_raw > 3'd4) ? 3'd4 : lastb_raw;
        dropped = (n > MAXW);
        nwr     = dropped ? MAXW : n;
        key     = $urandom;

        for (int k = 0; k < MAXW; k++) fill_words[k] = $urandom;
        fill_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fill_req = 1'b0;

        for (int k = 0; k < n; k++) words.push_back(use_preset ? preset[k] : $urandom);
        // Reference buffer: bytes past the final word's byte count keep whatever was there before.
        for (int k = 0; k < nwr; k++) begin
            v = words[k];
            if (k == n - 1) begin
                for (int b = int'(lb); b < 4; b++) v[8*b +: 8] = fill_words[k][8*b +: 8];
            end
            expw.push_back(v ^ key);
        end

        wr0  = wr_q.size();
        eg0  = eg_q.size();
        wsum = 0;
        for (int k = 0; k < n; k++) begin
            push_word(words[k], k == n - 1, (k == n - 1) ? lastb_raw : 3'($urandom_range(0, 7)), waits);
            wsum += waits;
        end
        #1;

        checks++;
        if (wsum != 0) begin
            failures++;
            $display("FAIL %s_ingress_rate: stall cycles=%0d want 0", tag, wsum);
        end
        checks++;
        if (wr_q.size() - wr0 != nwr) begin
            failures++;
            $display("FAIL %s_write_count: got %0d want %0d", tag, wr_q.size() - wr0, nwr);
        end
        ncmp = (wr_q.size() - wr0 < nwr) ? wr_q.size() - wr0 : nwr;
        bad  = 0;
        for (int k = 0; k < ncmp; k++) begin
            w = wr_q[wr0 + k];
            if (w.addr !== BASE + 32'(4 * k) || w.data !== words[k] ||
                w.width !== ((k == n - 1) ? {1'b0, lb} : 4'd4)) begin
                bad = 1;
                $display("  write %0d: addr=%h width=%0d data=%h", k, w.addr, w.width, w.data);
            end
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s_write_fields: got mismatching addr/width/data (listed above) want base+4k / 4 or %0d / word", tag, lb);
        end

        if (dropped) begin
            bad = 0;
            for (int c = 0; c < 4; c++) begin
                if (proc_start_o !== 1'b0 || mem_sel_o !== 1'b0 || in_ready_o !== 1'b1 || out_valid_o !== 1'b0) bad = 1;
                @(negedge clk);
                #1;
            end
            checks++;
            if (bad || eg_q.size() != eg0) begin
                failures++;
                $display("FAIL %s_drop_idle: proc_start=%b in_ready=%b egress=%0d want 0/1/0",
                         tag, proc_start_o, in_ready_o, eg_q.size() - eg0);
            end
            drop_exp++;
            return;
        end

        checks++;
        if (proc_start_o !== 1'b1 || mem_sel_o !== 1'b1) begin
            failures++;
            $display("FAIL %s_proc_start_latency: proc_start=%b mem_sel=%b want 1/1", tag, proc_start_o, mem_sel_o);
        end

        // Ingress tries to push a word during the whole processor window; it must be held off.
        in_valid_i = 1'b1;
        in_data_i  = $urandom;
        in_last_i  = 1'b1;
        in_bytes_i = 3'd4;
        xor_key    = key;
        bad        = 0;
        for (cyc = 0; cyc < proc_lat + 2; cyc++) begin
            if (proc_start_o !== 1'b1 || mem_sel_o !== 1'b1 || in_ready_o !== 1'b0 ||
                mem_ce_o !== 1'b0 || out_valid_o !== 1'b0) bad = 1;
            xor_req = (cyc == 0);
            if (cyc == proc_lat + 1) begin
                in_valid_i   = 1'b0;
                proc_ready_i = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            #1;
        end
        xor_req      = 1'b0;
        proc_ready_i = 1'b0;

        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s_proc_window: start/sel/in_ready/ce/out_valid deviated, want 1/1/0/0/0", tag);
        end
        checks++;
        if (wr_q.size() - wr0 != nwr) begin
            failures++;
            $display("FAIL %s_proc_stall: writes=%0d want %0d", tag, wr_q.size() - wr0, nwr);
        end
        checks++;
        if (proc_start_o !== 1'b0 || mem_sel_o !== 1'b0 || out_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL %s_send_latency: proc_start=%b mem_sel=%b out_valid=%b want 0/0/1",
                     tag, proc_start_o, mem_sel_o, out_valid_o);
        end

        stalled = 0;
        bad     = 0;
        guard   = 0;
        cyc     = 0;
        while (eg_q.size() - eg0 < nwr && guard < 500) begin
            case (ready_mode)
                0:       out_ready_i = 1'b1;
                1:       out_ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready_i = ($urandom_range(0, 2) != 0);
            endcase
            #1;
            if (stalled && (out_valid_o !== 1'b1 || out_data_o !== hold_data ||
                            mem_addr_o !== hold_addr || out_last_o !== hold_last)) bad = 1;
            stalled   = out_valid_o && !out_ready_i;
            hold_data = out_data_o;
            hold_addr = mem_addr_o;
            hold_last = out_last_o;
            @(negedge clk);
            guard++;
            cyc++;
        end
        out_ready_i = 1'b0;
        #1;

        checks++;
        if (eg_q.size() - eg0 != nwr) begin
            failures++;
            $display("FAIL %s_egress_count: got %0d want %0d", tag, eg_q.size() - eg0, nwr);
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s_egress_hold: outputs changed during a stall, want stable", tag);
        end
        if (ready_mode == 0) begin
            checks++;
            if (cyc != nwr) begin
                failures++;
                $display("FAIL %s_egress_rate: cycles=%0d want %0d", tag, cyc, nwr);
            end
        end
        ncmp = (eg_q.size() - eg0 < nwr) ? eg_q.size() - eg0 : nwr;
        for (int k = 0; k < ncmp; k++) begin
            e = eg_q[eg0 + k];
            checks++;
            if (e.data !== expw[k] || e.last !== (k == n - 1) || e.addr !== BASE + 32'(4 * k) ||
                e.bytes !== ((k == n - 1) ? lb : 3'd4)) begin
                failures++;
                $display("FAIL %s_egress_word%0d: got data=%h last=%b bytes=%0d addr=%h want %h/%b/%0d/%h",
                         tag, k, e.data, e.last, e.bytes, e.addr, expw[k], k == n - 1,
                         (k == n - 1) ? lb : 3'd4, BASE + 32'(4 * k));
            end
        end
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || out_last_o !== 1'b0 || out_bytes_o !== 3'd0) begin
            failures++;
            $display("FAIL %s_back_to_idle: out_valid=%b in_ready=%b last=%b bytes=%0d want 0/1/0/0",
                     tag, out_valid_o, in_ready_o, out_last_o, out_bytes_o);
        end
        pkt_exp++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (in_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready_o);
        end
        checks++;
        if ({out_valid_o, out_last_o, out_bytes_o, proc_start_o, mem_sel_o, mem_ce_o, mem_we_o} !== 9'd0) begin
            failures++;
            $display("FAIL reset_ctrl: valid=%b last=%b bytes=%0d start=%b sel=%b ce=%b we=%b want all 0",
                     out_valid_o, out_last_o, out_bytes_o, proc_start_o, mem_sel_o, mem_ce_o, mem_we_o);
        end
        checks++;
        if (mem_addr_o !== 32'd0 || mem_width_o !== 4'd0 || mem_data_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_mem_bus: addr=%h width=%0d data=%h want 0", mem_addr_o, mem_width_o, mem_data_o);
        end
        checks++;
        if (proc_pkt_addr_o !== BASE) begin
            failures++;
            $display("FAIL reset_pkt_addr: got %h want %h", proc_pkt_addr_o, BASE);
        end
`ifdef DISPATCH_STATS_EN
        @(negedge clk);
        checks++;
        if (pkt_cnt_o !== 16'd0 || drop_cnt_o !== 16'd0) begin
            failures++;
            $display("FAIL reset_stats: pkt=%0d drop=%0d want 0/0", pkt_cnt_o, drop_cnt_o);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready_o);
        end
    endtask

    task automatic test_basic();
        preset[0] = 32'h1122_3344;
        preset[1] = 32'h5566_7788;
        preset[2] = 32'hAABB_CCDD;
        run_packet("basic3", 3, 3'd2, 1, 0, 1'b1);
    endtask

    task automatic test_single();
        run_packet("single", 1, 3'd1, 0, 0, 1'b0);
        run_packet("single_b0", 1, 3'd0, 2, 0, 1'b0);
    endtask

    task automatic test_overflow();
        run_packet("full4", 4, 3'd7, 1, 0, 1'b0);
        run_packet("ovf6", 6, 3'd2, 1, 0, 1'b0);
        run_packet("ovf5_last", 5, 3'd3, 1, 0, 1'b0);
        run_packet("after_ovf", 2, 3'd3, 1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_packet("bp", 4, 3'd3, 2, 1, 1'b0);
    endtask

    task automatic test_slow_proc();
        run_packet("slow", 3, 3'd4, 20, 0, 1'b0);
    endtask

    task automatic test_rst_mid();
        int waits;
        push_word($urandom, 1'b0, 3'd4, waits);
        push_word($urandom, 1'b0, 3'd4, waits);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready_o !== 1'b0 || mem_ce_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_recv_during: in_ready=%b ce=%b want 0/0", in_ready_o, mem_ce_o);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready_o !== 1'b1 || proc_start_o !== 1'b0 || mem_sel_o !== 1'b0 || out_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_recv_after: in_ready=%b start=%b sel=%b valid=%b want 1/0/0/0",
                     in_ready_o, proc_start_o, mem_sel_o, out_valid_o);
        end
        run_packet("rst_follow", 1, 3'd3, 1, 0, 1'b0);

        push_word($urandom, 1'b1, 3'd4, waits);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (proc_start_o !== 1'b0 || mem_sel_o !== 1'b0 || in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_proc_after: start=%b sel=%b in_ready=%b want 0/0/1", proc_start_o, mem_sel_o, in_ready_o);
        end
        run_packet("rst_proc_follow", 2, 3'd1, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            run_packet($sformatf("rand%0d", i), $urandom_range(1, 6), 3'($urandom_range(0, 7)),
                       $urandom_range(0, 6), 2, 1'b0);
        end
    endtask

    task automatic test_stats();
`ifdef DISPATCH_STATS_EN
        checks++;
        if (pkt_cnt_o !== 16'(pkt_exp) || drop_cnt_o !== 16'(drop_exp)) begin
            failures++;
            $display("FAIL stats_counts: pkt=%0d drop=%0d want %0d/%0d", pkt_cnt_o, drop_cnt_o, pkt_exp, drop_exp);
        end
`endif
    endtask

    initial begin
        rst          = 1'b1;
        in_valid_i   = 1'b0;
        in_data_i    = 32'd0;
        in_last_i    = 1'b0;
        in_bytes_i   = 3'd0;
        out_ready_i  = 1'b0;
        proc_ready_i = 1'b0;
        fill_req     = 1'b0;
        xor_req      = 1'b0;
        xor_key      = 32'd0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_single();
        test_overflow();
        test_backpressure();
        test_slow_proc();
        test_rst_mid();
        test_random();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
